// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a fixed
// window of GATE_CYCLES clk_in cycles and reports count, overflow and decade code.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 27
) (
    input  logic             clk_in,
    input  logic             arstn,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_count,
    output logic             overflow,
    output logic [2:0]       range_code
);

    localparam int            GW   = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] edge_nxt;
    logic             ovf_nxt;

    // Decades above the counter's range can never match, so comparing in 64 bits
    // makes unrepresentable thresholds unreachable without special-casing.
    function automatic logic [2:0] decode(input logic [CNT_W-1:0] cnt, input logic ov);
        logic [2:0]      code;
        logic [63:0]     dec;
        code = 3'd0;
        dec  = 64'd10;
        for (int i = 0; i < 7; i++) begin
            if (64'(cnt) >= dec) code = 3'(i + 1);
            dec = dec * 64'd10;
        end
        if (ov) code = 3'd7;
        return code;
    endfunction

    // NOTE: arstn is a synchronous reset here, so it is deliberately absent from the
    // sensitivity list; state updates use non-blocking assignments so every flop
    // samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!arstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Counter value including this cycle's edge, so a rise in the final gate
    // cycle lands in the reported result.
    always_comb begin
        edge_nxt = edge_cnt;
        ovf_nxt  = ovf;
        if (rise) begin
            if (&edge_cnt) ovf_nxt  = 1'b1;
            else           edge_nxt = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!arstn) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            meas_count <= '0;
            overflow   <= 1'b0;
            range_code <= 3'd0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || continuous) begin
                        state    <= GATE;
                        busy     <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt + GW'(1);
                    edge_cnt <= edge_nxt;
                    ovf      <= ovf_nxt;
                    if (gate_cnt == LAST) begin
                        state      <= DONE;
                        meas_valid <= 1'b1;
                        meas_count <= edge_nxt;
                        overflow   <= ovf_nxt;
                        range_code <= decode(edge_nxt, ovf_nxt);
                    end
                end
                DONE: begin
                    if (continuous) begin
                        state    <= GATE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed vector table plus randomized traffic checked
// every cycle against a history-based reference model.
module tb_freq_meter;

    localparam int G    = 100;
    localparam int WA   = 27;
    localparam int WB   = 5;
    localparam int MAXC = 40000;

    logic          clk_in = 1'b0;
    logic          arstn = 1'b0;
    logic          sig_in = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b;
    logic [WA-1:0] count_a;
    logic [WB-1:0] count_b;
    logic [2:0]    range_a, range_b;

    int n_checks = 0;
    int n_errors = 0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(WA)) dut_a (
        .clk_in(clk_in), .arstn(arstn), .sig_in(sig_in), .start(start),
        .continuous(continuous), .busy(busy_a), .meas_valid(valid_a),
        .meas_count(count_a), .overflow(ovf_a), .range_code(range_a));

    freq_meter #(.GATE_CYCLES(G), .CNT_W(WB)) dut_b (
        .clk_in(clk_in), .arstn(arstn), .sig_in(sig_in), .start(start),
        .continuous(continuous), .busy(busy_b), .meas_valid(valid_b),
        .meas_count(count_b), .overflow(ovf_b), .range_code(range_b));

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_range(input longint c, input bit ov);
        logic [2:0] code;
        longint     v;
        if (ov) return 3'd7;
        code = 3'd0;
        v    = c;
        while (v >= 10 && code < 3'd7) begin
            v    = v / 10;
            code = code + 3'd1;
        end
        return code;
    endfunction

    // ---------------- reference model ----------------
    // h[t] is the sig_in level captured at clock edge t. An edge counted at edge t
    // is a 0->1 step between the samples taken three and two edges earlier.
    bit          h [MAXC];
    int          cyc = 3;
    bit          armed = 1'b0;
    bit          m_busy, m_gate, m_valid;
    int          m_acc;
    logic [63:0] e_cnt_a, e_cnt_b;
    bit          e_ovf_a, e_ovf_b;
    logic [2:0]  e_rng_a, e_rng_b;

    initial begin
        longint raw;
        m_busy = 0; m_gate = 0; m_valid = 0; m_acc = 0;
        e_cnt_a = '0; e_cnt_b = '0; e_ovf_a = 0; e_ovf_b = 0; e_rng_a = '0; e_rng_b = '0;
        forever begin
            @(posedge clk_in);
            if (cyc < MAXC - 1) cyc++;
            h[cyc] = arstn && sig_in;
            if (!arstn) begin
                h[cyc-1] = 1'b0;
                h[cyc-2] = 1'b0;
                armed    = 1'b1;
                m_busy = 0; m_gate = 0; m_valid = 0;
                e_cnt_a = '0; e_cnt_b = '0; e_ovf_a = 0; e_ovf_b = 0;
                e_rng_a = '0; e_rng_b = '0;
            end else begin
                m_valid = 0;
                if (!m_busy) begin
                    if (start || continuous) begin
                        m_busy = 1; m_gate = 1; m_acc = cyc;
                    end
                end else if (m_gate) begin
                    if (cyc == m_acc + G) begin
                        raw = 0;
                        for (int t = m_acc + 1; t <= cyc; t++)
                            if (h[t-2] && !h[t-3]) raw++;
                        e_ovf_a = raw > ((64'd1 << WA) - 1);
                        e_cnt_a = e_ovf_a ? ((64'd1 << WA) - 1) : raw;
                        e_ovf_b = raw > ((64'd1 << WB) - 1);
                        e_cnt_b = e_ovf_b ? ((64'd1 << WB) - 1) : raw;
                        e_rng_a = ref_range(e_cnt_a, e_ovf_a);
                        e_rng_b = ref_range(e_cnt_b, e_ovf_b);
                        m_valid = 1; m_gate = 0;
                    end
                end else begin
                    if (continuous) begin
                        m_gate = 1; m_acc = cyc;
                    end else begin
                        m_busy = 0;
                    end
                end
            end
        end
    end

    // Whole output bundle of each DUT compared every cycle, away from the edge.
    initial begin
        forever begin
            @(negedge clk_in);
            if (armed) begin
                check("sb_a", 72'({busy_a, valid_a, ovf_a, range_a, 64'(count_a)}),
                      72'({m_busy, m_valid, e_ovf_a, e_rng_a, e_cnt_a}));
                check("sb_b", 72'({busy_b, valid_b, ovf_b, range_b, 64'(count_b)}),
                      72'({m_busy, m_valid, e_ovf_b, e_rng_b, e_cnt_b}));
            end
        end
    end

    // ---------------- sig_in generator ----------------
    int sig_mode   = 0;   // 0 constant level, 1 square wave, 2 random holds
    int sig_period = 10;
    bit sig_level  = 1'b0;

    initial begin
        int ph   = 0;
        int hold = 0;
        forever begin
            @(negedge clk_in);
            case (sig_mode)
                0: sig_in = sig_level;
                1: begin
                    ph     = (ph + 1) % sig_period;
                    sig_in = (ph < sig_period / 2);
                end
                default: begin
                    if (hold == 0) begin
                        sig_in = 1'($urandom_range(0, 1));
                        hold   = $urandom_range(1, 6);
                    end
                    hold--;
                end
            endcase
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input int n);
        @(negedge clk_in);
        arstn = 1'b0; start = 1'b0; continuous = 1'b0;
        repeat (n) @(negedge clk_in);
        arstn = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk_in); start = 1'b1;
        @(negedge clk_in); start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int lat);
        bit seen;
        lat  = 0;
        seen = 0;
        while (!seen && lat < limit) begin
            @(negedge clk_in);
            lat++;
            seen = valid_a;
        end
        check("valid_seen", 72'(seen), 72'(1));
    endtask

    typedef struct {
        int period;   // 0 = constant level
        bit level;
        int cnt_a;
        int rng_a;
        int cnt_b;
        bit ovf_b;
        int rng_b;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   lat, n_busy, n_val, n;

        vecs[0] = '{10,  1'b0, 10, 1, 10, 1'b0, 1};
        vecs[1] = '{2,   1'b0, 50, 1, 31, 1'b1, 7};
        vecs[2] = '{0,   1'b1, 0,  0, 0,  1'b0, 0};
        vecs[3] = '{4,   1'b0, 25, 1, 25, 1'b0, 1};
        vecs[4] = '{20,  1'b0, 5,  0, 5,  1'b0, 0};
        vecs[5] = '{100, 1'b0, 1,  0, 1,  1'b0, 0};

        // Reset state, idle with no requests
        do_reset(3);
        repeat (5) @(negedge clk_in);
        check("rst_busy",  72'(busy_a),  72'(0));
        check("rst_valid", 72'(valid_a), 72'(0));
        check("rst_count", 72'(count_a), 72'(0));
        check("rst_ovf",   72'(ovf_a),   72'(0));
        check("rst_range", 72'(range_a), 72'(0));

        // Directed single-shot table
        foreach (vecs[i]) begin
            sig_mode   = (vecs[i].period == 0) ? 0 : 1;
            sig_period = (vecs[i].period == 0) ? 10 : vecs[i].period;
            sig_level  = vecs[i].level;
            do_reset(3);
            repeat (8) @(negedge clk_in);
            pulse_start();
            wait_valid(G + 20, lat);
            check($sformatf("v%0d_latency", i), 72'(lat), 72'(G));
            check($sformatf("v%0d_cnt_a", i), 72'(count_a), 72'(vecs[i].cnt_a));
            check($sformatf("v%0d_rng_a", i), 72'(range_a), 72'(vecs[i].rng_a));
            check($sformatf("v%0d_ovf_a", i), 72'(ovf_a), 72'(0));
            check($sformatf("v%0d_cnt_b", i), 72'(count_b), 72'(vecs[i].cnt_b));
            check($sformatf("v%0d_ovf_b", i), 72'(ovf_b), 72'(vecs[i].ovf_b));
            check($sformatf("v%0d_rng_b", i), 72'(range_b), 72'(vecs[i].rng_b));
            @(negedge clk_in);
            check($sformatf("v%0d_busy_after", i), 72'({busy_a, valid_a}), 72'(0));
        end

        // Continuous mode with stray start pulses, then drop continuous mid-gate
        sig_mode = 1; sig_period = 10;
        do_reset(3);
        @(negedge clk_in); continuous = 1'b1;
        wait_valid(G + 20, lat);
        check("cont_first_lat", 72'(lat), 72'(G + 1));
        check("cont_first_cnt", 72'(count_a), 72'(10));
        for (int p = 1; p <= 3; p++) begin
            bit seen;
            lat = 0; seen = 0;
            while (!seen && lat < 3 * G) begin
                @(negedge clk_in);
                lat++;
                start = (lat == 40 || lat == 77);
                seen  = valid_a;
            end
            start = 1'b0;
            check($sformatf("cont_spacing_%0d", p), 72'(lat), 72'(G + 1));
            check($sformatf("cont_cnt_%0d", p), 72'(count_a), 72'(10));
        end
        begin
            bit seen;
            lat = 0; seen = 0;
            while (!seen && lat < 3 * G) begin
                @(negedge clk_in);
                lat++;
                if (lat == 30) continuous = 1'b0;
                seen = valid_a;
            end
            check("cont_last_spacing", 72'(lat), 72'(G + 1));
        end
        n_val = 0;
        repeat (2 * G) begin
            @(negedge clk_in);
            n_val += int'(valid_a);
        end
        check("cont_tail_valids", 72'(n_val), 72'(0));
        check("cont_tail_busy", 72'(busy_a), 72'(0));

        // Start coincident with DONE is dropped; mid-gate reset aborts the gate
        do_reset(3);
        repeat (4) @(negedge clk_in);
        pulse_start();
        wait_valid(G + 20, lat);
        check("done_first_cnt", 72'(count_a), 72'(10));
        start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        n_busy = 0; n_val = 0;
        repeat (G + 20) begin
            @(negedge clk_in);
            n_busy += int'(busy_a);
            n_val  += int'(valid_a);
        end
        check("done_start_busy",  72'(n_busy), 72'(0));
        check("done_start_valid", 72'(n_val),  72'(0));
        pulse_start();
        repeat (50) @(negedge clk_in);
        arstn = 1'b0;
        @(negedge clk_in);
        check("abort_busy",  72'(busy_a),  72'(0));
        check("abort_count", 72'(count_a), 72'(0));
        check("abort_range", 72'(range_a), 72'(0));
        repeat (2) @(negedge clk_in);
        arstn = 1'b1;
        n_val = 0;
        repeat (G) begin
            @(negedge clk_in);
            n_val += int'(valid_a);
        end
        check("abort_no_valid", 72'(n_val), 72'(0));
        pulse_start();
        wait_valid(G + 20, lat);
        check("fresh_latency", 72'(lat), 72'(G));
        check("fresh_count",   72'(count_a), 72'(10));

        // Randomized traffic: random sig_in, starts, continuous toggles, resets
        sig_mode = 2;
        n_val = 0;
        for (int it = 0; it < 25; it++) begin
            continuous = ($urandom_range(0, 3) == 0);
            @(negedge clk_in); start = 1'b1;
            n = $urandom_range(50, 320);
            for (int c = 0; c < n; c++) begin
                @(negedge clk_in);
                n_val += int'(valid_a);
                start = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 99) == 0) continuous = ~continuous;
                if (it % 8 == 7 && c == n / 2) begin
                    arstn = 1'b0;
                    repeat (3) @(negedge clk_in);
                    arstn = 1'b1;
                end
            end
            start = 1'b0;
        end
        continuous = 1'b0;
        repeat (2 * G + 10) @(negedge clk_in);
        check("rand_saw_results", 72'(n_val > 0), 72'(1));
        check("rand_idle_at_end", 72'(busy_a), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Reciprocal counterpart of the DDFS clock divider: measures the frequency of an asynchronous input (divider output looped back, or an external test signal) by counting its rising edges over a fixed gate of GATE_CYCLES clk_in cycles. It reports the raw count, an overflow flag, and a 3-bit decade range code aligned with the divider's freq_cntrl decade encoding. It supports single-shot (start pulse) and continuous back-to-back measurement.

Parameters:
GATE_CYCLES, 50000000, gate length in clk_in cycles. With a 50 MHz clk_in, the count is in Hz. Must be >= 2.
CNT_W, 27, width of the edge counter and meas_count. Must be >= 24 for range codes 0..7 to be reachable.

Ports:
clk_in  input  1  system clock
arstn  input  1  reset, synchronous, active-low
sig_in  input  1  asynchronous signal under measurement
start  input  1  single-cycle request to begin one measurement; sampled only in IDLE
continuous  input  1  level; when high, a new gate starts automatically after each DONE
busy  output  1  high in GATE and DONE states
meas_valid  output  1  one-cycle pulse; meas_count, overflow and range_code are updated in the same cycle
meas_count  output  CNT_W  rising edges counted in the last completed gate (saturating)
overflow  output  1  last completed gate saturated the edge counter
range_code  output  3  decade of meas_count: 0 for 0..9, 1 for 10..99, ... 6 for 10^6..10^7-1, 7 for >=10^7 or overflow

Behaviour:
- Reset (arstn=0 at a clk_in edge):
  - state goes to IDLE.
  - busy, meas_valid, meas_count, overflow and range_code are all 0.
  - Synchronizer flops, gate counter and edge counter are cleared.
  - Reset is allowed at any point, including mid-gate; the gate is aborted and no meas_valid is produced.
- Input conditioning:
  - 2-flop synchronizer (s1, s2) followed by a history flop s3.
  - rise = s2 & ~s3, evaluated every cycle.
  - Minimum resolvable sig_in high and low time is 1 clk_in cycle each. Faster inputs alias, which is acceptable.
- FSM states: IDLE, GATE, DONE.
  - IDLE: if start=1 or continuous=1, go to GATE and load gate_cnt=0, edge_cnt=0, ovf=0. Otherwise stay.
  - GATE:
    - gate_cnt increments every cycle.
    - On rise: if edge_cnt is all-ones, set ovf=1 and hold edge_cnt; otherwise increment edge_cnt.
    - A rise in the final GATE cycle is counted.
    - When gate_cnt == GATE_CYCLES-1, go to DONE. GATE therefore lasts exactly GATE_CYCLES cycles.
  - DONE (one cycle):
    - Register meas_count=edge_cnt, overflow=ovf, range_code=decode(edge_cnt, ovf); meas_valid=1 for this cycle.
    - Next state is GATE (counters reloaded as in IDLE) if continuous=1, else IDLE.
- Latency: with start accepted at edge k, meas_valid is high in cycle k+GATE_CYCLES+1. In continuous mode, meas_valid pulses are spaced exactly GATE_CYCLES+1 cycles apart.
- start is ignored while busy; a start pulse coincident with DONE is dropped.
- Deasserting continuous during GATE lets the current gate finish normally, then the FSM returns to IDLE.
- Outputs hold their last values between meas_valid pulses.
- range_code decode:
  - Combinational compare of edge_cnt against the constants 10, 100, ..., 10^7, each zero-extended or truncated to CNT_W.
  - A constant that is not representable in CNT_W is treated as unreachable.
  - ovf=1 forces 7.
- gate_cnt width is clog2(GATE_CYCLES); no wrap occurs because the counter is reloaded on each gate entry.
- Edges that occur in IDLE or DONE are not counted; s3 still tracks s2 there.

Test Plan:
1. Hold arstn=0 for 3 cycles, then release -> busy=0, meas_valid=0, meas_count=0, overflow=0, range_code=0; FSM stays in IDLE with start=0 and continuous=0.
2. GATE_CYCLES=100; sig_in square wave with period 10 clk (any phase); start pulse at cycle k -> meas_valid exactly at k+101, meas_count=10, range_code=1, overflow=0, busy low at k+102.
3. GATE_CYCLES=100; sig_in held high (rising after reset) -> meas_count=0 if the rise occurs before start, otherwise 1; range_code=0.
4. GATE_CYCLES=100; sig_in toggles every clk (period 2) -> meas_count=50, range_code=1. With CNT_W=5 -> meas_count=31, overflow=1, range_code=7.
5. continuous=1, period-10 input, extra start pulses injected mid-gate -> meas_valid every 101 cycles, each with count 10; start pulses have no effect. Drop continuous mid-gate -> exactly one more meas_valid, then IDLE.
6. Assert arstn=0 at gate cycle 50 -> next cycle busy=0 and all outputs 0; no meas_valid for the aborted gate; a fresh start then completes normally.
